// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter for one shared memory port with a hung-cycle watchdog
module mem_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 18,
    parameter int DW      = 18,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [NREQ-1:0] r_rsp_valid;
    logic            r_rsp_err;
    logic [DW-1:0]   r_rsp_rdata;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic            w_accept;
    logic            w_busy;
    logic            w_timeout;
    logic [NREQ-1:0] w_owner_oh;

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_busy     = (r_state == S_BUSY);
    assign w_accept   = (r_state == S_IDLE) && w_found;
    // Watchdog fires only when no ack arrives in the last allowed cycle; ack wins a tie
    assign w_timeout  = (TIMEOUT != 0) && w_busy && !mem_ack && (r_cnt == CNT_LAST);
    assign w_owner_oh = NREQ'(1) << r_owner;

    // Grant is gated by reset so it drops the instant reset is asserted
    assign req_ready  = (rst_n && w_accept) ? (NREQ'(1) << w_winner) : '0;

    assign mem_req    = w_busy;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: accept moves to BUSY, ack or watchdog expiry returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY: if (mem_ack || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command capture, round-robin pointer, watchdog counter and one-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_accept) begin
                r_owner     <= w_winner;
                r_ptr       <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
                r_mem_we    <= req_we[w_winner];
                r_mem_addr  <= req_addr[w_winner * AW +: AW];
                r_mem_wdata <= req_wdata[w_winner * DW +: DW];
                r_cnt       <= '0;
            end
            if (w_busy) begin
                if (mem_ack) begin
                    r_rsp_valid <= w_owner_oh;
                    r_rsp_rdata <= r_mem_we ? '0 : mem_rdata;
                end else if (w_timeout) begin
                    r_rsp_valid <= w_owner_oh;
                    r_rsp_err   <= 1'b1;
                end else if (TIMEOUT != 0) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 18;
    localparam int DW   = 18;
    localparam int TO   = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_err;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_req;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_ack;
    logic [DW-1:0]      mem_rdata;

    mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        return v[1] ? 1 : 0;
    endfunction

    // Observation logs taken from the DUT pins
    int grant_q[$];
    int grant_cyc[$];
    int rsp_owner[$];
    int rsp_errq[$];
    int rsp_data[$];
    int rsp_cyc[$];

    // Memory responder: acks in the ack_lat-th cycle of mem_req (0 = never)
    int          ack_lat   = 1;
    logic [17:0] rdata_val = 18'h0;
    logic        spur      = 1'b0;
    int          mcnt      = 0;
    int          last_high = 0;
    logic        ack_we;
    logic [17:0] ack_addr;
    logic [17:0] ack_wdata;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        ack_we    = 1'b0;
        ack_addr  = '0;
        ack_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mem_req) begin
                mcnt++;
                mem_ack = (ack_lat != 0) && (mcnt == ack_lat);
                mem_rdata = mem_ack ? rdata_val : 18'h0;
                if (mem_ack) begin
                    ack_we    = mem_we;
                    ack_addr  = mem_addr;
                    ack_wdata = mem_wdata;
                end
            end else begin
                if (mcnt != 0) last_high = mcnt;
                mcnt      = 0;
                mem_ack   = spur;
                mem_rdata = spur ? 18'h3FFFF : 18'h0;
            end
        end
    end

    // Transaction-level model: one command in flight, response due the cycle after it ends
    logic              m_busy = 1'b0;
    int                m_owner = 0;
    int                m_ptr = 0;
    int                m_high = 0;
    logic              m_we = 1'b0;
    logic [17:0]       m_addr = '0;
    logic [17:0]       m_wdata = '0;
    logic [NREQ-1:0]   m_rsp = '0;
    logic              m_err = 1'b0;
    logic [17:0]       m_rdata = '0;
    logic [NREQ-1:0]   exp_ready;
    int                win;
    int                mdl_i;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_high = 0;
            m_rsp = '0; m_err = 1'b0; m_rdata = '0;
        end else begin
            win = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    mdl_i = (m_ptr + k) % NREQ;
                    if (win < 0 && req_valid[mdl_i]) win = mdl_i;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) begin
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            if (m_rsp != 0) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            end
            if ((req_valid & req_ready) != 0) begin
                grant_q.push_back(oh_idx(req_valid & req_ready));
                grant_cyc.push_back(cyc);
            end
            if (rsp_valid != 0) begin
                rsp_owner.push_back(oh_idx(rsp_valid));
                rsp_errq.push_back(int'(rsp_err));
                rsp_data.push_back(int'(rsp_rdata));
                rsp_cyc.push_back(cyc);
            end
            m_rsp = '0; m_err = 1'b0; m_rdata = '0;
            if (m_busy) begin
                m_high++;
                if (mem_ack) begin
                    m_rsp[m_owner] = 1'b1;
                    m_rdata = m_we ? 18'h0 : mem_rdata;
                    m_busy = 1'b0;
                end else if (TO != 0 && m_high == TO) begin
                    m_rsp[m_owner] = 1'b1;
                    m_err = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (win >= 0) begin
                m_busy  = 1'b1;
                m_owner = win;
                m_ptr   = (win + 1) % NREQ;
                m_high  = 0;
                m_we    = req_we[win];
                m_addr  = req_addr[win*AW +: AW];
                m_wdata = req_wdata[win*DW +: DW];
            end
        end
    end

    // Issue one command from requester i and wait for its response
    task automatic single(input int i, input logic we, input logic [17:0] addr,
                          input logic [17:0] wdata, input int lat, input logic [17:0] rv);
        int g0, r0;
        bit ok;
        ack_lat   = lat;
        rdata_val = rv;
        g0 = grant_q.size();
        r0 = rsp_owner.size();
        @(posedge clk); #2;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW]  = addr;
        req_wdata[i*DW +: DW] = wdata;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(posedge clk); #2;
            if (grant_q.size() > g0) ok = 1;
        end
        if (!ok) chk("accept_wait", 32'd0, 32'd1);
        req_valid[i] = 1'b0;
        ok = 0;
        for (int n = 0; n < 12 && !ok; n++) begin
            @(posedge clk); #2;
            if (rsp_owner.size() > r0) ok = 1;
        end
        if (!ok) chk("rsp_wait", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    int  g0, r0, s;
    bit  ok;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;

        // Reset in the middle of a hung transaction
        ack_lat = 0;
        g0 = grant_q.size();
        req_valid[1] = 1'b1; req_addr[1*AW +: AW] = 18'h00ABC;
        ok = 0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(posedge clk); #2;
            if (grant_q.size() > g0) ok = 1;
        end
        if (!ok) chk("accept_wait", 32'd0, 32'd1);
        req_valid[1] = 1'b0;
        chk("busy_before_rst", 32'(mem_req), 32'd1);
        r0 = rsp_owner.size();
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("dropped_no_rsp", 32'(rsp_owner.size()), 32'(r0));
        ack_lat = 1;
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_addr = {18'h00111, 18'h00222};
        ok = 0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(posedge clk); #2;
            if (grant_q.size() > g0) ok = 1;
        end
        if (!ok) chk("accept_wait", 32'd0, 32'd1);
        req_valid = '0;
        if (ok) chk("first_grant_after_rst", 32'(grant_q[grant_q.size()-1]), 32'd0);
        repeat (4) @(posedge clk);
        #2;

        // Single read from requester 1
        s = rsp_owner.size();
        single(1, 1'b0, 18'h3FFFF, 18'h0, 3, 18'h2A5A5);
        if (rsp_owner.size() > s) begin
            chk("read_owner", 32'(rsp_owner[s]), 32'd1);
            chk("read_err", 32'(rsp_errq[s]), 32'd0);
            chk("read_rdata", 32'(rsp_data[s]), 32'h2A5A5);
            chk("read_latency", 32'(rsp_cyc[s] - grant_cyc[grant_cyc.size()-1]), 32'd4);
        end
        chk("read_addr", 32'(ack_addr), 32'h3FFFF);
        chk("read_one_rsp", 32'(rsp_owner.size()), 32'(s + 1));

        // Fairness: both requesters held valid for 8 grants
        ack_lat = 1;
        g0 = grant_q.size();
        req_we = '0;
        req_addr = {18'h01001, 18'h00100};
        req_valid = 2'b11;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(posedge clk); #2;
            if (grant_q.size() >= g0 + 8) ok = 1;
        end
        req_valid = '0;
        if (!ok) chk("fair_wait", 32'd0, 32'd1);
        else begin
            for (int j = 0; j < 8; j++) begin
                chk("fair_grant", 32'(grant_q[g0+j]), 32'(j % 2));
                if (j > 0) chk("fair_spacing", 32'(grant_cyc[g0+j] - grant_cyc[g0+j-1]), 32'd2);
            end
        end
        repeat (4) @(posedge clk);
        #2;

        // Write from requester 0
        s = rsp_owner.size();
        single(0, 1'b1, 18'h00010, 18'h12345, 2, 18'h3FFFF);
        if (rsp_owner.size() > s) begin
            chk("write_owner", 32'(rsp_owner[s]), 32'd0);
            chk("write_rdata", 32'(rsp_data[s]), 32'd0);
        end
        chk("write_we", 32'(ack_we), 32'd1);
        chk("write_wdata", 32'(ack_wdata), 32'h12345);
        chk("write_addr", 32'(ack_addr), 32'h00010);

        // Watchdog expiry with no ack at all
        s = rsp_owner.size();
        single(1, 1'b0, 18'h00020, 18'h0, 0, 18'h0);
        if (rsp_owner.size() > s) begin
            chk("to_owner", 32'(rsp_owner[s]), 32'd1);
            chk("to_err", 32'(rsp_errq[s]), 32'd1);
            chk("to_rdata", 32'(rsp_data[s]), 32'd0);
            chk("to_latency", 32'(rsp_cyc[s] - grant_cyc[grant_cyc.size()-1]), 32'd5);
        end
        chk("to_mem_req_cycles", 32'(last_high), 32'd4);

        // Ack in the last allowed cycle beats the watchdog
        s = rsp_owner.size();
        single(1, 1'b0, 18'h00030, 18'h0, 4, 18'h15555);
        if (rsp_owner.size() > s) begin
            chk("edge_err", 32'(rsp_errq[s]), 32'd0);
            chk("edge_rdata", 32'(rsp_data[s]), 32'h15555);
        end
        chk("edge_mem_req_cycles", 32'(last_high), 32'd4);

        // Spurious ack while idle
        s = rsp_owner.size();
        spur = 1'b1;
        @(posedge clk); #2;
        spur = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("spurious_no_rsp", 32'(rsp_owner.size()), 32'(s));
        chk("spurious_idle", 32'(mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
